tmds_deserializer: RTL and testbench
====================================

Name: tmds_deserializer

Overview:
Receive side of the TMDS link: one serial TMDS channel, one bit per clk_TMDS cycle, LSB of each 10-bit symbol first. The block rebuilds 10-bit symbols and finds the word boundary by bit-slipping until DVI control tokens repeat. It flags control tokens and decodes them to their 2-bit control value. One instance per colour channel feeds the TMDS decoder in the capture/loopback test path.

Parameters:
LOCK_COUNT, 4, consecutive control-token words needed to declare lock.
SEARCH_WORDS, 64, words examined at one bit phase before a slip is issued.
TIMEOUT_WORDS, 4096, consecutive non-token words tolerated while locked before lock is dropped.

Ports:
clk_TMDS  input  1  bit-rate clock (10x pixel clock); only clock in the block
rst_n  input  1  asynchronous active-low reset
TMDS_in  input  1  serial TMDS bit, already synchronous to clk_TMDS
symbol  output  10  recovered symbol; symbol[0] = first bit received
symbol_valid  output  1  one-cycle pulse per recovered symbol
is_ctrl  output  1  symbol is one of the four control tokens; qualified by symbol_valid
ctrl  output  2  decoded control value {c1,c0}; 00 when is_ctrl=0
locked  output  1  word alignment achieved
bitslip  output  1  one-cycle pulse when the boundary is moved by one bit

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: symbol=0, symbol_valid=0, is_ctrl=0, ctrl=0, locked=0, bitslip=0.
  - Internal: shift register=0, phase counter=0, FSM=SEARCH, all word counters=0.
- Shift register: every edge, sr <= {TMDS_in, sr[9:1]}.
- Phase counter: counts 0..9. A boundary edge is an edge with cnt==9 and no slip-hold active.
- Boundary edge:
  - symbol <= {TMDS_in, sr[9:1]}.
  - symbol_valid=1 for exactly that one registered cycle.
  - cnt <= 0.
- Latency: symbol is visible in the cycle after the edge that samples its 10th bit.
- Token map (word[9:0]):
  - 1101010100 -> ctrl 00
  - 0010101011 -> ctrl 01
  - 0101010100 -> ctrl 10
  - 1010101011 -> ctrl 11
  - Any other word -> is_ctrl=0, ctrl=00.
  - is_ctrl and ctrl are registered together with symbol.
- Slip:
  - The phase counter holds at 0 for one extra edge (slip-hold). The symbol period becomes 11 bits once, moving the boundary one bit later.
  - bitslip pulses for one cycle, together with the symbol_valid of the boundary that triggered it.
  - The symbol from that boundary is still output.
- FSM SEARCH, evaluated only on boundary edges:
  - Token word: tok_cnt++. Any other word: tok_cnt=0.
  - search_cnt++ on every word.
  - tok_cnt reaches LOCK_COUNT -> LOCKED; locked=1 from the next cycle; idle_cnt=0.
  - Else if search_cnt reaches SEARCH_WORDS -> slip; search_cnt=0, tok_cnt=0.
  - Lock and slip conditions on the same word: lock wins, no slip.
- FSM LOCKED, evaluated only on boundary edges:
  - Token word: idle_cnt=0. Any other word: idle_cnt++.
  - idle_cnt reaches TIMEOUT_WORDS -> SEARCH; locked=0 next cycle; tok_cnt=0, search_cnt=0.
  - No slips are issued while LOCKED.
- Counter widths: $clog2(param+1). Counters saturate by construction (cleared on state change) and never wrap.
- Symbols are output regardless of lock state; consumers qualify them with locked.
- rst_n asserted mid-word or mid-slip: immediate return to reset values; the partial word is discarded.

Test Plan:
1. Token stream 1101010100 repeated, bit-aligned to the phase counter from reset release -> symbol_valid every 10 cycles, is_ctrl=1, ctrl=00; locked=1 one cycle after the 4th token word; bitslip never asserted.
2. Same stream delayed 3 bits -> bitslip pulses every 64 words; locked=1 after at most 9 slips; afterwards symbol=1101010100 every word.
3. Locked link, cycle through all four tokens -> ctrl shows 00, 01, 10, 11 in order; data word 0111110000 gives is_ctrl=0, ctrl=00.
4. Locked link, then 4096 consecutive data words -> locked falls one cycle after the 4096th word; a following token burst relocks after 4 tokens.
5. Misaligned stream with rst_n pulsed low for 2 cycles mid-slip -> all outputs 0 during reset; search restarts with search_cnt=0 and the slip-hold cleared.
6. Token words alternating with one non-token word in SEARCH -> tok_cnt never reaches 4; slips continue every 64 words; locked stays 0.

Source files
------------

// File: rtl/tmds_deserializer.sv
// TMDS serial-to-symbol deserializer with bit-slip word alignment.
// Locks on repeated DVI control tokens and decodes them to {c1,c0}.
module tmds_deserializer #(
  parameter int LOCK_COUNT    = 4,
  parameter int SEARCH_WORDS  = 64,
  parameter int TIMEOUT_WORDS = 4096
) (
  input  logic       clk_TMDS,
  input  logic       rst_n,
  input  logic       TMDS_in,
  output logic [9:0] symbol,
  output logic       symbol_valid,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic       bitslip
);

  localparam int TW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(SEARCH_WORDS + 1);
  localparam int IW = $clog2(TIMEOUT_WORDS + 1);

  typedef enum logic {
    S_SEARCH,
    S_LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    sr_q;
  logic [3:0]    cnt_q, cnt_d;
  logic          hold_q, hold_d;
  logic [TW-1:0] tok_q, tok_d;
  logic [SW-1:0] srch_q, srch_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [9:0]    sym_q;
  logic          valid_q;
  logic          isc_q;
  logic [1:0]    ctrl_q;
  logic          slip_q;

  logic [9:0]    word;
  logic          boundary;
  logic          tok;
  logic [1:0]    tok_ctrl;
  logic          slip;

  assign word     = {TMDS_in, sr_q[9:1]};
  assign boundary = (cnt_q == 4'd9) && !hold_q;

  always_comb begin
    tok      = 1'b1;
    tok_ctrl = 2'b00;
    unique case (1'b1)
      word == 10'b1101010100: tok_ctrl = 2'b00;
      word == 10'b0010101011: tok_ctrl = 2'b01;
      word == 10'b0101010100: tok_ctrl = 2'b10;
      word == 10'b1010101011: tok_ctrl = 2'b11;
      default:                tok      = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tok_d   = tok_q;
    srch_d  = srch_q;
    idle_d  = idle_q;
    slip    = 1'b0;
    if (boundary) begin
      unique case (state_q)
        S_SEARCH: begin
          tok_d  = tok ? tok_q + TW'(1) : '0;
          srch_d = srch_q + SW'(1);
          // lock takes priority over a slip due on the same word
          if (tok_d == TW'(LOCK_COUNT)) begin
            state_d = S_LOCKED;
            tok_d   = '0;
            srch_d  = '0;
            idle_d  = '0;
          end else if (srch_d == SW'(SEARCH_WORDS)) begin
            slip   = 1'b1;
            srch_d = '0;
            tok_d  = '0;
          end
        end
        S_LOCKED: begin
          idle_d = tok ? '0 : idle_q + IW'(1);
          if (idle_d == IW'(TIMEOUT_WORDS)) begin
            state_d = S_SEARCH;
            idle_d  = '0;
            tok_d   = '0;
            srch_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // a slip holds the counter at 0 one extra edge: an 11-bit period once
  always_comb begin
    hold_d = slip;
    if (boundary || hold_q) cnt_d = 4'd0;
    else                    cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk_TMDS or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SEARCH;
      sr_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      tok_q   <= '0;
      srch_q  <= '0;
      idle_q  <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      isc_q   <= 1'b0;
      ctrl_q  <= 2'b00;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= word;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      tok_q   <= tok_d;
      srch_q  <= srch_d;
      idle_q  <= idle_d;
      valid_q <= boundary;
      slip_q  <= slip;
      if (boundary) begin
        sym_q  <= word;
        isc_q  <= tok;
        ctrl_q <= tok_ctrl;
      end
    end
  end

  assign symbol       = sym_q;
  assign symbol_valid = valid_q;
  assign is_ctrl      = isc_q;
  assign ctrl         = ctrl_q;
  assign locked       = (state_q == S_LOCKED);
  assign bitslip      = slip_q;

endmodule

// File: tb/tb_tmds_deserializer.sv
// Self-checking bench for tmds_deserializer.
// Word-level reference model compared against every output each cycle.
module tb_tmds_deserializer;

  localparam int LOCK = 4;
  localparam int SRCH = 64;
  localparam int TMO  = 4096;
  localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                     10'b0101010100, 10'b1010101011};
  localparam logic [9:0] DWORD = 10'b0111110000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tin = 1'b0;
  logic [9:0] symbol;
  logic       symbol_valid;
  logic       is_ctrl;
  logic [1:0] ctrl;
  logic       locked;
  logic       bitslip;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tmds_deserializer #(
    .LOCK_COUNT(LOCK),
    .SEARCH_WORDS(SRCH),
    .TIMEOUT_WORDS(TMO)
  ) dut (
    .clk_TMDS(clk),
    .rst_n(rst_n),
    .TMDS_in(tin),
    .symbol(symbol),
    .symbol_valid(symbol_valid),
    .is_ctrl(is_ctrl),
    .ctrl(ctrl),
    .locked(locked),
    .bitslip(bitslip)
  );

  wire [15:0] obs = {symbol, symbol_valid, is_ctrl, ctrl, locked, bitslip};

  // reference model: words of 10 bits (11 once after a slip)
  logic       m_hist[$];
  logic       stim[$];
  int         m_n, m_per, m_tok, m_srch, m_idle;
  logic       m_lock;
  logic [9:0] e_sym;
  logic       e_valid, e_isc, e_slip;
  logic [1:0] e_ctrl;

  function automatic logic [15:0] exp_vec();
    return {e_sym, e_valid, e_isc, e_ctrl, m_lock, e_slip};
  endfunction

  function automatic int tok_index(input logic [9:0] w);
    for (int k = 0; k < 4; k++) if (w == TOK[k]) return k;
    return -1;
  endfunction

  function automatic logic [9:0] nontoken();
    logic [9:0] w;
    w = 10'($urandom);
    while (tok_index(w) >= 0) w = 10'($urandom);
    return w;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_n = 0; m_per = 10; m_tok = 0; m_srch = 0; m_idle = 0;
    m_lock = 1'b0;
    e_sym = '0; e_valid = 1'b0; e_isc = 1'b0; e_slip = 1'b0; e_ctrl = '0;
  endtask

  task automatic model_step(input logic b);
    logic [9:0] w;
    int k;
    m_hist.push_back(b);
    if (m_hist.size() > 10) void'(m_hist.pop_front());
    m_n++;
    e_valid = 1'b0;
    e_slip  = 1'b0;
    if (m_n == m_per) begin
      for (int i = 0; i < 10; i++) w[i] = m_hist[i];
      m_n = 0; m_per = 10;
      e_sym = w; e_valid = 1'b1;
      k = tok_index(w);
      e_isc  = (k >= 0);
      e_ctrl = (k >= 0) ? k[1:0] : 2'b00;
      if (!m_lock) begin
        m_tok = e_isc ? m_tok + 1 : 0;
        m_srch++;
        if (m_tok == LOCK) begin
          m_lock = 1'b1; m_tok = 0; m_srch = 0; m_idle = 0;
        end else if (m_srch == SRCH) begin
          m_per = 11; e_slip = 1'b1; m_srch = 0; m_tok = 0;
        end
      end else begin
        m_idle = e_isc ? 0 : m_idle + 1;
        if (m_idle == TMO) begin
          m_lock = 1'b0; m_tok = 0; m_srch = 0; m_idle = 0;
        end
      end
    end
  endtask

  task automatic tick(input logic b);
    tin = b;
    @(posedge clk);
    model_step(b);
    #1;
  endtask

  task automatic add_word(input logic [9:0] w);
    for (int k = 0; k < 10; k++) stim.push_back(w[k]);
  endtask

  task automatic add_bits(input int n);
    for (int k = 0; k < n; k++) stim.push_back(1'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tin = 1'b0;
    stim.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_bad++; $display("FAIL reset_init got %h want 0000", obs);
    end
    do_reset();
    add_bits(25);
    while (stim.size() > 0) begin
      tick(stim.pop_front());
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL reset_run got %h want %h", obs, exp_vec());
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_bad++; $display("FAIL reset_midword got %h want 0000", obs);
    end
  endtask

  task automatic test_aligned();
    int slips = 0, vcnt = 0;
    do_reset();
    for (int i = 0; i < 8; i++) add_word(TOK[0]);
    for (int i = 0; i < 80; i++) begin
      tick(stim.pop_front());
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL aligned got %h want %h", obs, exp_vec());
      end
      slips += int'(bitslip);
      vcnt  += int'(symbol_valid);
      if (i == 38 || i == 39) begin
        n_cmp++;
        if (locked !== (i == 39)) begin
          n_bad++; $display("FAIL aligned_lock bit=%0d got %b want %b", i, locked, i == 39);
        end
      end
    end
    n_cmp++;
    if (slips != 0 || vcnt != 8) begin
      n_bad++; $display("FAIL aligned_counts slips=%0d valids=%0d want 0/8", slips, vcnt);
    end
  endtask

  task automatic test_misaligned();
    int slips = 0;
    do_reset();
    add_bits(3);
    for (int i = 0; i < 650; i++) add_word(TOK[0]);
    while (stim.size() > 0) begin
      tick(stim.pop_front());
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL misalign got %h want %h", obs, exp_vec());
      end
      slips += int'(bitslip);
    end
    n_cmp++;
    if (locked !== 1'b1 || slips < 1 || slips > 9 || symbol !== TOK[0]) begin
      n_bad++;
      $display("FAIL misalign_end locked=%b slips=%0d sym=%b want 1/1..9/%b",
               locked, slips, symbol, TOK[0]);
    end
  endtask

  task automatic test_ctrl();
    int widx = 0;
    do_reset();
    for (int i = 0; i < 4; i++) add_word(TOK[0]);
    for (int i = 0; i < 4; i++) add_word(TOK[i]);
    add_word(DWORD);
    for (int i = 0; i < 20; i++)
      add_word(($urandom_range(0, 1) != 0) ? TOK[$urandom_range(0, 3)] : nontoken());
    while (stim.size() > 0) begin
      tick(stim.pop_front());
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL ctrl got %h want %h", obs, exp_vec());
      end
      if (e_valid) begin
        if (widx >= 4 && widx <= 8) begin
          n_cmp++;
          if ({is_ctrl, ctrl} !== ((widx == 8) ? 3'b000 : {1'b1, 2'(widx - 4)})) begin
            n_bad++;
            $display("FAIL ctrl_seq word=%0d got %b%b", widx, is_ctrl, ctrl);
          end
        end
        widx++;
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) add_word(TOK[0]);
    for (int i = 0; i < TMO; i++) add_word(nontoken());
    while (stim.size() > 1) begin
      tick(stim.pop_front());
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        if (n_bad < 50) $display("FAIL timeout got %h want %h", obs, exp_vec());
      end
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL timeout_before got %b want 1", locked);
    end
    tick(stim.pop_front());
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++; $display("FAIL timeout_drop got %b want 0", locked);
    end
    for (int i = 0; i < 4; i++) add_word(TOK[$urandom_range(0, 3)]);
    while (stim.size() > 0) begin
      tick(stim.pop_front());
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL relock got %h want %h", obs, exp_vec());
      end
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL relock_end got %b want 1", locked);
    end
  endtask

  task automatic test_reset_mid_slip();
    int words = 0;
    bit seen = 0;
    do_reset();
    add_bits($urandom_range(1, 9));
    for (int i = 0; i < 70; i++) add_word(TOK[0]);
    while (stim.size() > 0 && !seen) begin
      tick(stim.pop_front());
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL slipreset_pre got %h want %h", obs, exp_vec());
      end
      seen = bitslip;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL slipreset_noslip got 0 want 1");
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_bad++; $display("FAIL slipreset_zero got %h want 0000", obs);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_bad++; $display("FAIL slipreset_hold got %h want 0000", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    stim.delete();
    add_bits(3);
    for (int i = 0; i < 70; i++) add_word(TOK[0]);
    seen = 0;
    while (stim.size() > 0) begin
      tick(stim.pop_front());
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL slipreset_post got %h want %h", obs, exp_vec());
      end
      if (!seen) words += int'(e_valid);
      if (bitslip) seen = 1;
    end
    n_cmp++;
    if (!seen || words != SRCH) begin
      n_bad++; $display("FAIL slipreset_first got %0d words want %0d", words, SRCH);
    end
  endtask

  task automatic test_alternating();
    int slips = 0;
    bit seen_lock = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      add_word(TOK[$urandom_range(0, 3)]);
      add_word(DWORD);
    end
    while (stim.size() > 0) begin
      tick(stim.pop_front());
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL alt got %h want %h", obs, exp_vec());
      end
      slips += int'(bitslip);
      if (locked) seen_lock = 1;
    end
    n_cmp++;
    if (seen_lock || slips != 3) begin
      n_bad++; $display("FAIL alt_end lock=%b slips=%0d want 0/3", seen_lock, slips);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) add_bits($urandom_range(1, 3));
      add_word(($urandom_range(0, 2) != 0) ? TOK[$urandom_range(0, 3)] : nontoken());
    end
    while (stim.size() > 0) begin
      tick(stim.pop_front());
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        if (n_bad < 50) $display("FAIL random got %h want %h", obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_ctrl();
    test_timeout();
    test_reset_mid_slip();
    test_alternating();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
